// File: rtl/aes_decrypt_core.sv
// AES inverse cipher, one round per clock, Nk = 4/6/8.
// Round keys come pre-expanded on all_keys; key 0 is the MSB slice.
module aes_decrypt_core #(
   parameter  int Nk = 4,
   localparam int Nr = Nk + 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          data_in,
   input  logic [(Nr+1)*128-1:0] all_keys,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          data_out,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } st_t;

   st_t          st, st_n;
   logic [3:0]   rc;
   logic [127:0] state;
   logic [127:0] isr, isb, ark, rnd, rkey;
   logic [127:0] rk [16];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // Field inverse as x^254; zero maps to zero.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] sq, r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   // Inverse S-box: undo the affine map, then invert.
   function automatic logic [7:0] isbox(input logic [7:0] b);
      logic [7:0] y;
      y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]}
        ^ {b[1:0], b[7:2]} ^ 8'h05;
      return ginv(y);
   endfunction

   // Byte i sits at row i%4, column i/4.
   function automatic logic [127:0] inv_shift_rows(
      input logic [127:0] x);
      logic [127:0] y;
      int src;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            src = r + 4 * ((c - r + 4) % 4);
            y[127-8*(r+4*c) -: 8] = x[127-8*src -: 8];
         end
      return y;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(
      input logic [127:0] x);
      logic [127:0] y;
      for (int i = 0; i < 16; i++)
         y[127-8*i -: 8] = isbox(x[127-8*i -: 8]);
      return y;
   endfunction

   function automatic logic [127:0] inv_mix(
      input logic [127:0] x);
      logic [127:0] y;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = x[127-32*c -: 8];
         a1 = x[119-32*c -: 8];
         a2 = x[111-32*c -: 8];
         a3 = x[103-32*c -: 8];
         y[127-32*c -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11)
                          ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
         y[119-32*c -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14)
                          ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
         y[111-32*c -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)
                          ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
         y[103-32*c -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13)
                          ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
      end
      return y;
   endfunction

   // Slot table of round keys; slots above Nr are tied off.
   for (genvar i = 0; i < 16; i++) begin : g_rk
      if (i <= Nr) begin : g_on
         assign rk[i] = all_keys[(Nr+1-i)*128-1 -: 128];
      end else begin : g_off
         assign rk[i] = '0;
      end
   end

   assign rkey = rk[rc];
   assign isr  = inv_shift_rows(state);
   assign isb  = inv_sub_bytes(isr);
   assign ark  = isb ^ rkey;
   assign rnd  = (rc == 4'd0) ? ark : inv_mix(ark);

   assign in_ready  = (st == IDLE) && !reset;
   assign busy      = (st == ROUND);
   assign out_valid = (st == DONE);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= IDLE;
      else       st <= st_n;
   end

   // Next-state: accept, run the rounds, wait for the consumer.
   always_comb begin
      st_n = st;
      unique case (st)
         IDLE:    if (in_valid)   st_n = ROUND;
         ROUND:   if (rc == 4'd0) st_n = DONE;
         DONE:    if (out_ready)  st_n = IDLE;
         default:                 st_n = IDLE;
      endcase
   end

   // Datapath: initial whitening, one round per cycle, result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rc       <= 4'd0;
         state    <= '0;
         data_out <= '0;
      end else begin
         if (st == IDLE && in_valid) begin
            state <= data_in ^ rk[Nr];
            rc    <= 4'(Nr - 1);
         end else if (st == ROUND) begin
            state <= rnd;
            if (rc != 4'd0) rc <= rc - 4'd1;
            else            data_out <= rnd;
         end
      end
   end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: a forward AES model encrypts random
// plaintexts; the three key sizes must decrypt them back.
module tb_aes_decrypt_core;

   logic clk = 1'b0;
   logic rst;
   logic         iv   [3];
   logic         rdy  [3];
   logic [127:0] din  [3];
   logic         ov   [3];
   logic         ordy [3];
   logic [127:0] dout [3];
   logic         bsy  [3];
   logic [11*128-1:0] ak4;
   logic [13*128-1:0] ak6;
   logic [15*128-1:0] ak8;

   int ncmp = 0;
   int nbad = 0;

   logic [31:0] w [60];

   always #5 clk = ~clk;

   aes_decrypt_core #(.Nk(4)) u4 (
      .clk(clk), .reset(rst),
      .in_valid(iv[0]), .in_ready(rdy[0]),
      .data_in(din[0]), .all_keys(ak4),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .data_out(dout[0]), .busy(bsy[0]));

   aes_decrypt_core #(.Nk(6)) u6 (
      .clk(clk), .reset(rst),
      .in_valid(iv[1]), .in_ready(rdy[1]),
      .data_in(din[1]), .all_keys(ak6),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .data_out(dout[1]), .busy(bsy[1]));

   aes_decrypt_core #(.Nk(8)) u8 (
      .clk(clk), .reset(rst),
      .in_valid(iv[2]), .in_ready(rdy[2]),
      .data_in(din[2]), .all_keys(ak8),
      .out_valid(ov[2]), .out_ready(ordy[2]),
      .data_out(dout[2]), .busy(bsy[2]));

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- forward AES reference ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a,
                                     input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] a,
                                     input int n);
      logic [15:0] t;
      t = {a, a} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [7:0] a, sq;
      a = 8'h01; sq = x;
      for (int i = 1; i < 8; i++) begin
         sq = gm(sq, sq);
         a  = gm(a, sq);
      end
      return a ^ rl(a, 1) ^ rl(a, 2) ^ rl(a, 3)
           ^ rl(a, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sb(x[31:24]), sb(x[23:16]),
              sb(x[15:8]),  sb(x[7:0])};
   endfunction

   function automatic void expand(input logic [255:0] key,
                                  input int nk);
      logic [31:0] t;
      logic [7:0]  rcon;
      int nw;
      nw = 4 * (nk + 7);
      rcon = 8'h01;
      for (int i = 0; i < nw; i++) begin
         if (i < nk) w[i] = key[255-32*i -: 32];
         else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
               rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
         end
      end
   endfunction

   function automatic logic [127:0] rkey(input int r);
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] enc(input logic [127:0] pt,
                                        input int nr);
      logic [127:0] s, t;
      logic [7:0] a0, a1, a2, a3;
      int src;
      s = pt ^ rkey(0);
      for (int r = 1; r <= nr; r++) begin
         t = s;
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) begin
               src = q + 4 * ((c + q) % 4);
               s[127-8*(q+4*c) -: 8] = sb(t[127-8*src -: 8]);
            end
         if (r < nr)
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
               a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
               s[127-32*c -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
               s[119-32*c -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
               s[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
               s[103-32*c -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
            end
         s = s ^ rkey(r);
      end
      return s;
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic int nrof(input int k);
      return 10 + 2 * k;
   endfunction

   task automatic set_keys(input int k, input logic [255:0] key);
      expand(key, 4 + 2 * k);
      for (int r = 0; r <= nrof(k); r++)
         case (k)
            0:       ak4[(11-r)*128-1 -: 128] = rkey(r);
            1:       ak6[(13-r)*128-1 -: 128] = rkey(r);
            default: ak8[(15-r)*128-1 -: 128] = rkey(r);
         endcase
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One block: accept, count edges to out_valid, stall, handshake.
   task automatic xact(input int k, input logic [127:0] ct,
                       input logic [127:0] pt, input int hold);
      int n;
      logic got;
      @(negedge clk);
      din[k] = ct; iv[k] = 1'b1; ordy[k] = 1'b0;
      n = 0;
      while (!rdy[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", 128'(rdy[k]), 128'd1);
      @(posedge clk);
      #1 iv[k] = 1'b0;
      chk("busy_after_accept", 128'(bsy[k]), 128'd1);
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
         @(posedge clk);
         n++;
         #1 got = ov[k];
      end
      chk("latency", 128'(n), 128'(nrof(k)));
      chk("plaintext", dout[k], pt);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         iv[k] = 1'b1; din[k] = ~ct;
         chk("stall_valid", 128'(ov[k]), 128'd1);
         chk("stall_data", dout[k], pt);
         chk("stall_ready", 128'(rdy[k]), 128'd0);
         chk("stall_busy", 128'(bsy[k]), 128'd0);
      end
      @(negedge clk);
      iv[k] = 1'b0; ordy[k] = 1'b1;
      @(posedge clk);
      #1 ordy[k] = 1'b0;
      chk("valid_cleared", 128'(ov[k]), 128'd0);
      chk("ready_again", 128'(rdy[k]), 128'd1);
   endtask

   // Two blocks with in_valid and out_ready held high.
   task automatic b2b(input int k);
      logic [127:0] pts [2];
      logic [127:0] cts [2];
      int acc [2];
      int nacc, nout;
      for (int i = 0; i < 2; i++) begin
         pts[i] = rnd128();
         cts[i] = enc(pts[i], nrof(k));
      end
      acc[0] = 0; acc[1] = 0;
      nacc = 0; nout = 0;
      ordy[k] = 1'b1;
      for (int cyc = 0; cyc < 80 && nout < 2; cyc++) begin
         @(negedge clk);
         if (ov[k]) begin
            chk("b2b_plaintext", dout[k], pts[nout]);
            nout++;
         end
         if (nacc < 2) begin
            din[k] = cts[nacc];
            iv[k]  = 1'b1;
            if (rdy[k]) begin
               acc[nacc] = cyc;
               nacc++;
            end
         end else iv[k] = 1'b0;
      end
      iv[k] = 1'b0;
      chk("b2b_outputs", 128'(nout), 128'd2);
      chk("b2b_spacing", 128'(acc[1] - acc[0]),
          128'(nrof(k) + 2));
      @(posedge clk);
      #1 ordy[k] = 1'b0;
      chk("b2b_idle", 128'(ov[k]), 128'd0);
   endtask

   localparam logic [127:0] PT  =
      128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT4 =
      128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT6 =
      128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT8 =
      128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K4 = {
      128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K6 = {
      192'h000102030405060708090a0b0c0d0e0f1011121314151617,
      64'h0};
   localparam logic [255:0] K8 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   initial begin
      logic [127:0] p, c;
      rst = 1'b1;
      ak4 = '0; ak6 = '0; ak8 = '0;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 128'(rdy[k]), 128'd0);
         chk("rst_valid", 128'(ov[k]), 128'd0);
         chk("rst_busy", 128'(bsy[k]), 128'd0);
         chk("rst_data", dout[k], 128'd0);
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++)
         chk("release_ready", 128'(rdy[k]), 128'd1);

      set_keys(0, K4);
      chk("model_ct4", enc(PT, 10), CT4);
      xact(0, CT4, PT, 0);
      set_keys(1, K6);
      chk("model_ct6", enc(PT, 12), CT6);
      xact(1, CT6, PT, 0);
      set_keys(2, K8);
      chk("model_ct8", enc(PT, 14), CT8);
      xact(2, CT8, PT, 0);

      xact(0, CT4, PT, 5);

      @(negedge clk);
      din[0] = CT4; iv[0] = 1'b1;
      @(posedge clk);
      #1 iv[0] = 1'b0;
      repeat (5) @(posedge clk);
      #2 chk("mid_busy", 128'(bsy[0]), 128'd1);
      rst = 1'b1;
      #1;
      chk("abort_valid", 128'(ov[0]), 128'd0);
      chk("abort_busy", 128'(bsy[0]), 128'd0);
      chk("abort_data", dout[0], 128'd0);
      chk("abort_ready", 128'(rdy[0]), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("abort_release", 128'(rdy[0]), 128'd1);
      xact(0, CT4, PT, 0);

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 3; i++) begin
            set_keys(k, {rnd128(), rnd128()});
            p = rnd128();
            c = enc(p, nrof(k));
            xact(k, c, p, int'($urandom_range(0, 2)));
         end

      set_keys(0, {rnd128(), rnd128()});
      b2b(0);
      set_keys(2, {rnd128(), rnd128()});
      b2b(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nbad);
      $finish;
   end

endmodule
